// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM unified memory bus arbiter.
// Struct fields are sized at the widest supported bus; the top narrows them to ADDR_W/DATA_W.
package mem_arb_pkg;
  localparam int MAX_ADDR_W = 32;
  localparam int MAX_DATA_W = 32;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUS_IF, ARB_BUS_D} arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] wdata;
    logic [3:0]            be;
  } bus_req_t;
endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant decision: data first unless fetch has been starved.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       if_req,
  input  logic       d_req,
  input  logic       if_flush,
  input  logic       mask_if,
  input  logic       mask_d,
  input  logic       starved,
  output arb_state_t grant
);
  logic ifEff, dEff;

  always_comb begin
    ifEff = if_req & ~mask_if;
    dEff  = d_req & ~mask_d;
    grant = ARB_IDLE;
    if (dEff && !(ifEff && starved)) grant = ARB_BUS_D;
    else if (ifEff && !if_flush)     grant = ARB_BUS_IF;
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between instruction fetch and data ports with a
// registered request, valid/ready wait states, registered read data and stalls.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);
  arb_state_t state, stateNext, grant;
  bus_req_t   busReg;
  logic [3:0] starveCnt;
  logic       flushPend, hs, arbEn, maskIf, maskD, starved;

  // mem_valid is a pure decode of the state register, so reset drops it at once
  assign mem_valid = (state != ARB_IDLE);
  assign mem_we    = busReg.we;
  assign mem_addr  = busReg.addr[ADDR_W-1:0];
  assign mem_wdata = busReg.wdata[DATA_W-1:0];
  assign mem_be    = busReg.be;

  assign hs      = mem_valid & mem_ready;
  assign arbEn   = (state == ARB_IDLE) | hs;
  // requester holds req through its ready pulse, so mask it in hs and hs+1
  assign maskIf  = ((state == ARB_BUS_IF) & hs) | if_ready;
  assign maskD   = ((state == ARB_BUS_D) & hs) | d_ready;
  assign starved = (starveCnt == 4'(STARVE_MAX));

  assign stall_if  = if_req & ~if_ready & ~if_flush;
  assign stall_mem = d_req & ~d_ready;

  mem_arb_pick uPick (
    .if_req   (if_req),
    .d_req    (d_req),
    .if_flush (if_flush),
    .mask_if  (maskIf),
    .mask_d   (maskD),
    .starved  (starved),
    .grant    (grant)
  );

  always_comb begin
    stateNext = state;
    if (arbEn) stateNext = grant;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ARB_IDLE;
    else        state <= stateNext;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busReg    <= '0;
      starveCnt <= '0;
      flushPend <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;

      if (arbEn && grant == ARB_BUS_IF) begin
        busReg.we    <= 1'b0;
        busReg.addr  <= MAX_ADDR_W'(if_addr);
        busReg.wdata <= '0;
        busReg.be    <= BE_WORD;
      end else if (arbEn && grant == ARB_BUS_D) begin
        busReg.we    <= d_we;
        busReg.addr  <= MAX_ADDR_W'(d_addr);
        busReg.wdata <= MAX_DATA_W'(d_wdata);
        busReg.be    <= d_be;
      end

      // a flushed fetch still finishes on the bus; only its ready is dropped
      if (hs && state == ARB_BUS_IF) begin
        if_rdata  <= mem_rdata;
        if_ready  <= ~(flushPend | if_flush);
        flushPend <= 1'b0;
      end else if (state == ARB_BUS_IF && if_flush) begin
        flushPend <= 1'b1;
      end

      if (hs && state == ARB_BUS_D) begin
        d_rdata <= mem_rdata;
        d_ready <= 1'b1;
      end

      if (!if_req)                                 starveCnt <= '0;
      else if (arbEn && grant == ARB_BUS_IF)       starveCnt <= '0;
      else if (arbEn && grant == ARB_BUS_D && !if_flush && !starved)
                                                   starveCnt <= starveCnt + 4'd1;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch, data priority, starvation, wait states, flush, reset.
module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [3:0]  d_be = '0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ready, d_ready, mem_valid, mem_we, stall_if, stall_mem;
  logic [3:0]  mem_be;
  int          nAsserts = 0;
  int          nFail = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_valid", 32'(mem_valid), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_ifrdy", 32'(if_ready), 32'd0);
    chk("rst_drdy", 32'(d_ready), 32'd0);
    chk("rst_ifrdata", if_rdata, 32'd0);
    chk("rst_drdata", d_rdata, 32'd0);
    reset = 1'b1;

    // 1: single fetch, minimum latency
    step();
    if_req = 1'b1; if_addr = 32'h100; mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    chk("t1_valid", 32'(mem_valid), 32'd1);
    chk("t1_addr", mem_addr, 32'h100);
    chk("t1_be", 32'(mem_be), 32'hF);
    chk("t1_we", 32'(mem_we), 32'd0);
    chk("t1_stall", 32'(stall_if), 32'd1);
    chk("t1_rdy_early", 32'(if_ready), 32'd0);
    step();
    chk("t1_ready", 32'(if_ready), 32'd1);
    chk("t1_rdata", if_rdata, 32'hDEADBEEF);
    chk("t1_stall_rdy", 32'(stall_if), 32'd0);
    chk("t1_idle", 32'(mem_valid), 32'd0);
    step();
    chk("t1_nodup", 32'(mem_valid), 32'd0);
    chk("t1_rdy_pulse", 32'(if_ready), 32'd0);
    if_req = 1'b0;
    step();

    // 2: simultaneous requests, data first, fetch follows without bubble
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h1234; d_be = 4'b0011;
    mem_rdata = 32'h11112222;
    step();
    chk("t2_d_valid", 32'(mem_valid), 32'd1);
    chk("t2_d_we", 32'(mem_we), 32'd1);
    chk("t2_d_addr", mem_addr, 32'h2000);
    chk("t2_d_wdata", mem_wdata, 32'h1234);
    chk("t2_d_be", 32'(mem_be), 32'h3);
    step();
    chk("t2_if_valid", 32'(mem_valid), 32'd1);
    chk("t2_if_addr", mem_addr, 32'h104);
    chk("t2_if_we", 32'(mem_we), 32'd0);
    chk("t2_if_be", 32'(mem_be), 32'hF);
    chk("t2_d_ready", 32'(d_ready), 32'd1);
    chk("t2_d_rdata", d_rdata, 32'h11112222);
    d_req = 1'b0; d_we = 1'b0;
    mem_rdata = 32'hCAFEF00D;
    step();
    chk("t2_if_ready", 32'(if_ready), 32'd1);
    chk("t2_if_rdata", if_rdata, 32'hCAFEF00D);
    chk("t2_d_pulse", 32'(d_ready), 32'd0);
    if_req = 1'b0;
    step();

    // 3: fetch pending through four data grants; fifth grant goes to fetch
    if_req = 1'b1; if_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000; d_be = 4'hF;
    for (int k = 0; k < 4; k++) begin
      if_flush = 1'b0;
      step();
      chk($sformatf("t3_d%0d_valid", k), 32'(mem_valid), 32'd1);
      chk($sformatf("t3_d%0d_addr", k), mem_addr, 32'h4000 + 32'(k * 4));
      if_flush = 1'b1;
      step();
      chk($sformatf("t3_d%0d_ready", k), 32'(d_ready), 32'd1);
      chk($sformatf("t3_d%0d_idle", k), 32'(mem_valid), 32'd0);
      step();
      d_addr = 32'h4000 + 32'((k + 1) * 4);
    end
    if_flush = 1'b0;
    step();
    chk("t3_if_addr", mem_addr, 32'h300);
    chk("t3_if_be", 32'(mem_be), 32'hF);
    step();
    chk("t3_if_ready", 32'(if_ready), 32'd1);
    chk("t3_d_after", mem_addr, 32'h4010);
    chk("t3_d_after_vld", 32'(mem_valid), 32'd1);
    if_req = 1'b0;
    step();
    d_req = 1'b0;
    step();
    step();
    chk("t3_drained", 32'(mem_valid), 32'd0);

    // 4: load with three wait states
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_be = 4'hF; mem_ready = 1'b0;
    step();
    d_addr = 32'hBAD0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t4_w%0d_valid", k), 32'(mem_valid), 32'd1);
      chk($sformatf("t4_w%0d_addr", k), mem_addr, 32'h3000);
      chk($sformatf("t4_w%0d_we", k), 32'(mem_we), 32'd0);
      chk($sformatf("t4_w%0d_stall", k), 32'(stall_mem), 32'd1);
      chk($sformatf("t4_w%0d_rdy", k), 32'(d_ready), 32'd0);
      if (k == 3) begin
        mem_ready = 1'b1; mem_rdata = 32'h55AA55AA;
      end
      step();
    end
    chk("t4_ready", 32'(d_ready), 32'd1);
    chk("t4_rdata", d_rdata, 32'h55AA55AA);
    chk("t4_stall_off", 32'(stall_mem), 32'd0);
    chk("t4_idle", 32'(mem_valid), 32'd0);
    step();
    chk("t4_pulse", 32'(d_ready), 32'd0);
    chk("t4_nodup", 32'(mem_valid), 32'd0);
    d_req = 1'b0;
    step();

    // 5: flush during an outstanding fetch
    if_req = 1'b1; if_addr = 32'h180; mem_ready = 1'b0;
    step();
    chk("t5_valid", 32'(mem_valid), 32'd1);
    chk("t5_addr", mem_addr, 32'h180);
    if_flush = 1'b1; if_addr = 32'h200;
    #1;
    chk("t5_stall_flush", 32'(stall_if), 32'd0);
    step();
    if_flush = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
    chk("t5_noabort", 32'(mem_valid), 32'd1);
    chk("t5_noabort_addr", mem_addr, 32'h180);
    step();
    chk("t5_no_ready", 32'(if_ready), 32'd0);
    chk("t5_idle", 32'(mem_valid), 32'd0);
    mem_rdata = 32'h600DCAFE;
    step();
    chk("t5_new_valid", 32'(mem_valid), 32'd1);
    chk("t5_new_addr", mem_addr, 32'h200);
    step();
    chk("t5_new_ready", 32'(if_ready), 32'd1);
    chk("t5_new_rdata", if_rdata, 32'h600DCAFE);
    if_req = 1'b0;
    step();

    // 6: reset while a store waits on the bus
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h5000; d_wdata = 32'h77; mem_ready = 1'b0;
    step();
    chk("t6_valid", 32'(mem_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_drop", 32'(mem_valid), 32'd0);
    chk("t6_async_addr", mem_addr, 32'd0);
    step();
    chk("t6_no_drdy", 32'(d_ready), 32'd0);
    chk("t6_held", 32'(mem_valid), 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    reset = 1'b1;
    step();
    if_req = 1'b1; if_addr = 32'h100; mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    chk("t6_f_valid", 32'(mem_valid), 32'd1);
    chk("t6_f_addr", mem_addr, 32'h100);
    chk("t6_f_we", 32'(mem_we), 32'd0);
    step();
    chk("t6_f_ready", 32'(if_ready), 32'd1);
    chk("t6_f_rdata", if_rdata, 32'hDEADBEEF);
    chk("t6_f_drdy", 32'(d_ready), 32'd0);
    if_req = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end
endmodule
